// File: rtl/apbspi_spi_slave_ctrl_if.sv
// SPI bus bundle shared by the APB-SPI slave controller and its bus drivers.
interface apbspi_spi_if;
  logic cs;
  logic sck;
  logic mosi;
  logic miso;

  modport slave  (input cs, input sck, input mosi, output miso);
  modport master (output cs, output sck, output mosi, input miso);
endinterface

// File: rtl/apbspi_spi_slave_ctrl.sv
// SPI mode-0, LSB-first slave frame controller between an oversampled SPI bus
// and TX/RX word FIFOs.
module apbspi_spi_slave_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_p,
  input  logic             nrst,
  apbspi_spi_if.slave      spi_if,
  input  logic             enable,
  input  logic             tx_fifo_empty,
  input  logic [WIDTH-1:0] tx_fifo_read_data,
  output logic             tx_fifo_pop,
  input  logic             rx_fifo_full,
  output logic [WIDTH-1:0] rx_fifo_write_data,
  output logic             rx_fifo_push,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             rx_overrun,
  output logic             tx_underrun
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0]    FILL = 2'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_pipe, sck_pipe, mosi_pipe;
  logic                   cs_sync, sck_sync, mosi_sync;
  logic                   cs_prev, sck_prev;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [1:0]             fill_cnt;
  logic                   armed;
  logic                   skip_fall;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       tx_shift, rx_shift;

  assign cs_sync   = cs_pipe[SYNC_STAGES-1];
  assign sck_sync  = sck_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_sync;
  assign cs_rise   = ~cs_prev & cs_sync;
  assign sck_rise  = ~sck_prev & sck_sync;
  assign sck_fall  = sck_prev & ~sck_sync;

  // A cs level held low through reset looks like a fall once the pipe refills;
  // only arm frame starts after a genuine high level has been seen post-refill.
  always_ff @(posedge clk_p or negedge nrst) begin
    if (!nrst) begin
      cs_pipe   <= '1;
      sck_pipe  <= '0;
      mosi_pipe <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_if.cs};
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_if.sck};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_if.mosi};
      cs_prev   <= cs_sync;
      sck_prev  <= sck_sync;
      if (fill_cnt != FILL) fill_cnt <= fill_cnt + 2'd1;
      else if (cs_sync)     armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk_p or negedge nrst) begin
    if (!nrst) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      tx_shift           <= '0;
      rx_shift           <= '0;
      skip_fall          <= 1'b0;
      tx_fifo_pop        <= 1'b0;
      rx_fifo_push       <= 1'b0;
      rx_fifo_write_data <= '0;
      frame_done         <= 1'b0;
      frame_abort        <= 1'b0;
      rx_overrun         <= 1'b0;
      tx_underrun        <= 1'b0;
    end else begin
      tx_fifo_pop  <= 1'b0;
      rx_fifo_push <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_underrun  <= 1'b0;
      if (sck_fall) skip_fall <= 1'b0;

      if (!enable) begin
        state     <= IDLE;
        skip_fall <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall && armed) state <= LOAD;
          LOAD: begin
            if (cs_rise) begin
              frame_abort <= 1'b1;
              state       <= IDLE;
            end else begin
              if (!tx_fifo_empty) begin
                tx_shift    <= tx_fifo_read_data;
                tx_fifo_pop <= 1'b1;
              end else begin
                tx_shift    <= '0;
                tx_underrun <= 1'b1;
              end
              bit_cnt <= '0;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (bit_cnt == FULL) begin
              frame_done         <= 1'b1;
              rx_fifo_write_data <= rx_shift;
              if (!rx_fifo_full) rx_fifo_push <= 1'b1;
              else               rx_overrun   <= 1'b1;
              state <= cs_sync ? IDLE : LOAD;
            end else if (cs_rise && !(sck_rise && bit_cnt == LAST)) begin
              frame_abort <= 1'b1;
              state       <= IDLE;
            end else begin
              if (sck_rise) begin
                rx_shift <= {mosi_sync, rx_shift[WIDTH-1:1]};
                bit_cnt  <= bit_cnt + CW'(1);
                // The trailing fall of the last bit must not disturb the next word.
                if (bit_cnt == LAST) skip_fall <= 1'b1;
              end
              if (sck_fall && !skip_fall) tx_shift <= {1'b0, tx_shift[WIDTH-1:1]};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy        = (state != IDLE);
  assign spi_if.miso = (!cs_sync && state != IDLE) ? tx_shift[0] : 1'b0;

endmodule

// File: tb/tb_apbspi_spi_slave_ctrl.sv
// Directed bench for apbspi_spi_slave_ctrl: bus-level SPI master plus FIFO models.
module tb_apbspi_spi_slave_ctrl;

  logic        clk_p = 1'b0;
  logic        nrst  = 1'b1;
  logic        enable = 1'b1;
  logic        tx_fifo_empty;
  logic [31:0] tx_fifo_read_data;
  logic        tx_fifo_pop;
  logic        rx_fifo_full = 1'b0;
  logic [31:0] rx_fifo_write_data;
  logic        rx_fifo_push;
  logic        busy, frame_done, frame_abort, rx_overrun, tx_underrun;

  apbspi_spi_if spi();

  apbspi_spi_slave_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_p              (clk_p),
    .nrst               (nrst),
    .spi_if             (spi),
    .enable             (enable),
    .tx_fifo_empty      (tx_fifo_empty),
    .tx_fifo_read_data  (tx_fifo_read_data),
    .tx_fifo_pop        (tx_fifo_pop),
    .rx_fifo_full       (rx_fifo_full),
    .rx_fifo_write_data (rx_fifo_write_data),
    .rx_fifo_push       (rx_fifo_push),
    .busy               (busy),
    .frame_done         (frame_done),
    .frame_abort        (frame_abort),
    .rx_overrun         (rx_overrun),
    .tx_underrun        (tx_underrun)
  );

  always #5 clk_p = ~clk_p;

  int tests = 0;
  int fails = 0;

  // Event totals, written only by the monitor.
  int pop_total = 0, push_total = 0, done_total = 0;
  int abort_total = 0, over_total = 0, under_total = 0;
  logic [31:0] push_log [0:31];

  // Snapshots, written only by the initial block.
  int s_pop, s_push, s_done, s_abort, s_over, s_under;
  int tx_start = 0;
  int tx_n = 0;
  logic [31:0] tx_words [0:7];
  int tx_idx;

  assign tx_idx            = pop_total - tx_start;
  assign tx_fifo_empty     = (tx_idx >= tx_n);
  assign tx_fifo_read_data = tx_fifo_empty ? 32'h0 : tx_words[tx_idx[2:0]];

  always @(posedge clk_p) begin
    if (tx_fifo_pop) pop_total++;
    if (rx_fifo_push) begin
      push_log[push_total % 32] = rx_fifo_write_data;
      push_total++;
    end
    if (frame_done)  done_total++;
    if (frame_abort) abort_total++;
    if (rx_overrun)  over_total++;
    if (tx_underrun) under_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_pop = pop_total;   s_push = push_total; s_done = done_total;
    s_abort = abort_total; s_over = over_total; s_under = under_total;
  endtask

  task automatic set_tx(input int n, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2);
    tx_words[0] = w0; tx_words[1] = w1; tx_words[2] = w2;
    tx_start = pop_total;
    tx_n = n;
  endtask

  // Master: sck half period 50 ns (10 clk_p cycles per bit). On the final bit of
  // a released frame cs rises together with the last sck rising edge.
  task automatic spi_frame(input logic [31:0] wr, input int nbits, input bit keep_cs,
                           output logic [31:0] rd);
    rd = '0;
    if (spi.cs) begin
      spi.cs = 1'b0;
      #200;
    end
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = wr[i];
      #50;
      rd[i] = spi.miso;
      spi.sck = 1'b1;
      if (i == nbits - 1 && !keep_cs) spi.cs = 1'b1;
      #50;
      spi.sck = 1'b0;
    end
    spi.mosi = 1'b0;
    if (!keep_cs) #200;
  endtask

  logic [31:0] rd, rd2, rd3;

  initial begin
    spi.cs = 1'b1; spi.sck = 1'b0; spi.mosi = 1'b0;
    for (int i = 0; i < 8; i++) tx_words[i] = '0;

    // Reset state
    #10 nrst = 1'b0;
    #20;
    check("rst_busy",  32'(busy), 0);
    check("rst_miso",  32'(spi.miso), 0);
    check("rst_pop",   32'(tx_fifo_pop), 0);
    check("rst_push",  32'(rx_fifo_push), 0);
    check("rst_wdata", rx_fifo_write_data, 0);
    nrst = 1'b1;
    #100;

    // Basic frame; cs rises with the final sck edge, which must not abort
    snap(); set_tx(1, 32'hA5A5_0F0F, 0, 0);
    spi_frame(32'h1234_5678, 32, 1'b0, rd);
    check("basic_miso",  rd, 32'hA5A5_0F0F);
    check("basic_push",  32'(push_total - s_push), 1);
    check("basic_data",  push_log[s_push % 32], 32'h1234_5678);
    check("basic_pop",   32'(pop_total - s_pop), 1);
    check("basic_done",  32'(done_total - s_done), 1);
    check("basic_abort", 32'(abort_total - s_abort), 0);
    check("basic_busy",  32'(busy), 0);

    // TX underrun
    snap(); set_tx(0, 0, 0, 0);
    spi_frame(32'hCAFE_F00D, 32, 1'b0, rd);
    check("under_pulse", 32'(under_total - s_under), 1);
    check("under_miso",  rd, 32'h0);
    check("under_pop",   32'(pop_total - s_pop), 0);
    check("under_push",  32'(push_total - s_push), 1);
    check("under_data",  push_log[s_push % 32], 32'hCAFE_F00D);

    // RX overrun
    snap(); set_tx(1, 32'h1111_1111, 0, 0);
    rx_fifo_full = 1'b1;
    spi_frame(32'hDEAD_BEEF, 32, 1'b0, rd);
    rx_fifo_full = 1'b0;
    check("over_pulse", 32'(over_total - s_over), 1);
    check("over_push",  32'(push_total - s_push), 0);
    check("over_done",  32'(done_total - s_done), 1);
    check("over_miso",  rd, 32'h1111_1111);

    // Abort after 13 bits, then a clean frame
    snap(); set_tx(2, 32'h0F0F_0F0F, 32'h8765_4321, 0);
    spi_frame(32'hFFFF_FFFF, 13, 1'b0, rd);
    check("abort_pulse", 32'(abort_total - s_abort), 1);
    check("abort_push",  32'(push_total - s_push), 0);
    check("abort_done",  32'(done_total - s_done), 0);
    check("abort_busy",  32'(busy), 0);
    check("abort_miso",  rd, 32'h0000_0F0F);
    snap();
    spi_frame(32'h1357_9BDF, 32, 1'b0, rd);
    check("post_abort_push", 32'(push_total - s_push), 1);
    check("post_abort_data", push_log[s_push % 32], 32'h1357_9BDF);
    check("post_abort_miso", rd, 32'h8765_4321);

    // Three back-to-back frames with cs held low
    snap(); set_tx(3, 32'h1, 32'h2, 32'h3);
    spi_frame(32'hAAAA_0001, 32, 1'b1, rd);
    spi_frame(32'hAAAA_0002, 32, 1'b1, rd2);
    spi_frame(32'hAAAA_0003, 32, 1'b0, rd3);
    check("b2b_miso0", rd,  32'h1);
    check("b2b_miso1", rd2, 32'h2);
    check("b2b_miso2", rd3, 32'h3);
    check("b2b_pop",   32'(pop_total - s_pop), 3);
    check("b2b_push",  32'(push_total - s_push), 3);
    check("b2b_data0", push_log[(s_push + 0) % 32], 32'hAAAA_0001);
    check("b2b_data1", push_log[(s_push + 1) % 32], 32'hAAAA_0002);
    check("b2b_data2", push_log[(s_push + 2) % 32], 32'hAAAA_0003);
    check("b2b_done",  32'(done_total - s_done), 3);
    check("b2b_abort", 32'(abort_total - s_abort), 0);

    // Reset mid-frame at bit 20, cs held low through release
    set_tx(3, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    spi_frame(32'h0BAD_CAFE, 20, 1'b1, rd);
    #20 nrst = 1'b0;
    snap();
    #20;
    check("midrst_busy",  32'(busy), 0);
    check("midrst_miso",  32'(spi.miso), 0);
    check("midrst_wdata", rx_fifo_write_data, 0);
    nrst = 1'b1;
    #200;
    check("rst_release_busy", 32'(busy), 0);
    check("rst_release_pop",  32'(pop_total - s_pop), 0);
    spi.cs = 1'b1;
    #100;

    // Frame while disabled is ignored entirely
    enable = 1'b0;
    spi_frame(32'h0BAD_CAFE, 32, 1'b0, rd);
    check("dis_pop",   32'(pop_total - s_pop), 0);
    check("dis_push",  32'(push_total - s_push), 0);
    check("dis_pulse", 32'((done_total - s_done) + (abort_total - s_abort) +
                           (over_total - s_over) + (under_total - s_under)), 0);
    check("dis_busy",  32'(busy), 0);
    check("dis_miso",  rd, 32'h0);
    check("dis_wdata", rx_fifo_write_data, 0);
    enable = 1'b1;
    #100;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
